// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES round count, round-controller state encoding and datapath stage codes
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_KWAIT = 3'd2,
    ST_ARK   = 3'd3,
    ST_SB    = 3'd4,
    ST_SR    = 3'd5,
    ST_MC    = 3'd6,
    ST_DONE  = 3'd7
  } aes_ctrl_state_e;

  typedef enum logic [2:0] {
    STAGE_NONE = 3'd0,
    STAGE_ARK  = 3'd1,
    STAGE_SB   = 3'd2,
    STAGE_SR   = 3'd3,
    STAGE_MC   = 3'd4
  } aes_stage_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES encryption round sequencer driving the datapath and key expansion
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       abort,
  input  logic       key_valid,
  output logic       key_start,
  output logic       dp_load,
  output logic       dp_en,
  output logic [2:0] stage,
  output logic [3:0] round,
  output logic       busy
);

  localparam logic [3:0] LastRound = 4'(NR);

  aes_ctrl_state_e state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic            abortable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // IDLE and DONE ignore abort so a finished ciphertext is never lost
  assign abortable = (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (abort && abortable) begin
      state_d = ST_IDLE;
      round_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          round_d = 4'd0;
          if (in_valid) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d = ST_KWAIT;
          round_d = 4'd0;
        end
        ST_KWAIT: begin
          if (key_valid) state_d = ST_ARK;
        end
        ST_ARK: begin
          if (round_q == LastRound) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SB;
            round_d = round_q + 4'd1;
          end
        end
        ST_SB: state_d = ST_SR;
        // final round skips MixColumns
        ST_SR: state_d = (round_q == LastRound) ? ST_KWAIT : ST_MC;
        ST_MC: state_d = ST_KWAIT;
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          round_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_start = 1'b0;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    stage     = STAGE_NONE;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_LOAD: begin
        key_start = 1'b1;
        dp_load   = 1'b1;
      end
      ST_ARK: begin
        dp_en = 1'b1;
        stage = STAGE_ARK;
      end
      ST_SB: begin
        dp_en = 1'b1;
        stage = STAGE_SB;
      end
      ST_SR: begin
        dp_en = 1'b1;
        stage = STAGE_SR;
      end
      ST_MC: begin
        dp_en = 1'b1;
        stage = STAGE_MC;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign round = round_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed table-driven bench for aes_round_ctrl
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, abort, key_valid;
  logic       key_start, dp_load, dp_en, busy;
  logic [2:0] stage;
  logic [3:0] round;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int stall_round;
    int stall_len;
    int bp_len;
    bit hold_valid;
    int exp_edge;
  } vec_t;

  vec_t vecs[5];
  int   exp_stage[40];
  int   exp_round[40];

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .abort(abort),
    .key_valid(key_valid), .key_start(key_start), .dp_load(dp_load),
    .dp_en(dp_en), .stage(stage), .round(round), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] outs();
    return {in_ready, out_valid, key_start, dp_load, dp_en, stage, round, busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic advance_to(input int s, input int r);
    for (int i = 0; i < 200 && !(dp_en && int'(stage) == s && int'(round) == r); i++) step();
    chk("reach_stage", {31'd0, (dp_en && int'(stage) == s && int'(round) == r)}, 1);
  endtask

  task automatic no_out(input string name, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 0);
  endtask

  task automatic run_block(input vec_t v);
    int  idx = 0, loads = 1, stalls = v.stall_len, edge_seen = 0;
    logic kwait, stalled;
    in_valid  = 1'b1;
    key_valid = 1'b1;
    out_ready = 1'b0;
    chk("idle_ready", {31'd0, in_ready}, 1);
    step();
    chk("load_pulse", {29'd0, dp_load, key_start, in_ready}, 3'b110);
    if (!v.hold_valid) in_valid = 1'b0;
    for (int e = 1; e <= 200 && edge_seen == 0; e++) begin
      kwait   = busy && !dp_en && !dp_load && !out_valid;
      stalled = kwait && int'(round) == v.stall_round && stalls > 0;
      key_valid = !stalled;
      if (stalled) stalls--;
      step();
      if (stalled)
        chk("stall_hold", {24'd0, dp_en, stage, round}, {24'd0, 1'b0, 3'd0, 4'(v.stall_round)});
      if (dp_load) loads++;
      if (dp_en) begin
        if (idx < 40) begin
          chk("trace_stage", {29'd0, stage}, exp_stage[idx]);
          chk("trace_round", {28'd0, round}, exp_round[idx]);
        end else begin
          chk("trace_len", idx, 39);
        end
        idx++;
      end
      if (out_valid) begin
        edge_seen = e;
        chk("out_valid_edge", e, v.exp_edge);
      end
    end
    chk("out_valid_seen", {31'd0, edge_seen != 0}, 1);
    chk("trace_count", idx, 40);
    chk("single_load", loads, 1);
    key_valid = 1'b1;
    for (int k = 0; k < v.bp_len; k++) begin
      step();
      chk("bp_hold", {27'd0, out_valid, round}, {27'd0, 1'b1, 4'd10});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("back_to_idle", {27'd0, in_ready, round}, {27'd0, 1'b1, 4'd0});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; key_valid = 1'b0;

    vecs[0] = '{stall_round: -1, stall_len: 0, bp_len: 0, hold_valid: 1'b0, exp_edge: 52};
    vecs[1] = '{stall_round:  5, stall_len: 3, bp_len: 0, hold_valid: 1'b0, exp_edge: 55};
    vecs[2] = '{stall_round: -1, stall_len: 0, bp_len: 4, hold_valid: 1'b1, exp_edge: 52};
    vecs[3] = '{stall_round:  0, stall_len: 2, bp_len: 1, hold_valid: 1'b0, exp_edge: 54};
    vecs[4] = '{stall_round: 10, stall_len: 1, bp_len: 0, hold_valid: 1'b0, exp_edge: 53};

    // ARK, (SB,SR,MC,ARK) x9, SB,SR,ARK
    exp_stage[0] = 1; exp_round[0] = 0;
    for (int r = 1, i = 1; r <= 10; r++) begin
      exp_stage[i] = 2; exp_round[i] = r; i++;
      exp_stage[i] = 3; exp_round[i] = r; i++;
      if (r < 10) begin
        exp_stage[i] = 4; exp_round[i] = r; i++;
      end
      exp_stage[i] = 1; exp_round[i] = r; i++;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {19'd0, outs()}, {19'd0, 13'b1_0_0_0_0_000_0000_0});
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", {19'd0, outs()}, {19'd0, 13'b1_0_0_0_0_000_0000_0});

    foreach (vecs[i]) run_block(vecs[i]);

    // abort in SubBytes of round 3
    key_valid = 1'b1;
    accept();
    advance_to(2, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {19'd0, outs()}, {19'd0, 13'b1_0_0_0_0_000_0000_0});
    no_out("abort_no_out", 60);

    // abort is ignored while in IDLE
    abort = 1'b1;
    step();
    chk("abort_in_idle", {31'd0, in_ready}, 1);
    abort = 1'b0;

    // abort in DONE must not drop the ciphertext
    accept();
    for (int i = 0; i < 200 && !out_valid; i++) step();
    chk("done_reached", {31'd0, out_valid}, 1);
    abort = 1'b1;
    repeat (2) step();
    chk("abort_in_done", {27'd0, out_valid, round}, {27'd0, 1'b1, 4'd10});
    abort = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("done_release", {31'd0, in_ready}, 1);

    // asynchronous reset in MixColumns of round 7
    accept();
    advance_to(4, 7);
    rst_n = 1'b0;
    #1;
    chk("reset_midblock", {19'd0, outs()}, {19'd0, 13'b1_0_0_0_0_000_0000_0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    no_out("reset_no_out", 60);
    chk("reset_idle_after", {31'd0, in_ready}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds (AES-128).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  requester has plaintext and master key ready.
REQ-005 SHALL have port in_ready  output  1  controller can accept a new block.
REQ-006 SHALL have port out_valid  output  1  ciphertext in datapath state register is final.
REQ-007 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-008 SHALL have port abort  input  1  synchronous cancel of the current block.
REQ-009 SHALL have port key_valid  input  1  key expansion has the round key for the current round.
REQ-010 SHALL have port key_start  output  1  pulse: key expansion loads master key, restarts at round 0.
REQ-011 SHALL have port dp_load  output  1  datapath state register loads plaintext.
REQ-012 SHALL have port dp_en  output  1  datapath executes the operation given by stage.
REQ-013 SHALL have port stage  output  3  0 none, 1 AddRoundKey, 2 SubBytes, 3 ShiftRows, 4 MixColumns.
REQ-014 SHALL have port round  output  4  current round index, 0..NR.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, LOAD, KWAIT, ARK, SB, SR, MC, DONE; all outputs are decoded from registered state and round (Moore).
REQ-017 SHALL drive in_ready high only in IDLE; on in_valid && in_ready, next state is LOAD.
REQ-018 SHALL drive dp_load and key_start high only in LOAD, for exactly one cycle; LOAD always goes to KWAIT with round = 0.
REQ-019 SHALL hold KWAIT while key_valid is low and go to ARK on the first cycle key_valid is high; key_valid is ignored in every other state.
REQ-020 SHALL assert dp_en with stage = 1 in ARK; from ARK, round < NR goes to SB with round incremented by 1, and round == NR goes to DONE.
REQ-021 SHALL sequence SB -> SR; from SR, round != NR goes to MC and round == NR goes to KWAIT, so the final round skips MixColumns.
REQ-022 SHALL sequence MC -> KWAIT; dp_en is high with the matching stage code in SB, SR and MC.
REQ-023 SHALL drive dp_en low and stage = 0 in IDLE, LOAD, KWAIT and DONE.
REQ-024 SHALL hold out_valid high in DONE until out_ready is high; on that cycle, next state is IDLE with round = 0.
REQ-025 SHALL raise out_valid exactly 52 rising edges after the accepting edge when key_valid is held high throughout.
REQ-026 SHALL hold round, stage and dp_en stable while stalled in KWAIT or DONE.
REQ-027 SHALL send abort high in LOAD, KWAIT, ARK, SB, SR or MC to IDLE on the next edge with round = 0 and no out_valid; abort takes priority over all other transitions.
REQ-028 SHALL ignore abort in IDLE and DONE, so a completed ciphertext is never dropped.
REQ-029 SHALL ignore in_valid while busy; a request is held by the requester, not queued.
REQ-030 SHALL send any unused state encoding to IDLE on the next edge.

Reset
REQ-031 SHALL, while rst_n is low, force state IDLE, round 0, in_ready 1 and all other outputs 0, including mid-block.
REQ-032 SHALL treat a block in progress at reset as discarded, with no out_valid afterwards.

Structure
REQ-033 SHALL take stage codes, state encoding and NR default from shared package aes_pkg, used with the AES top and the key expansion.
REQ-034 SHALL be a single module with no sub-module; state register and round counter are local.

Verification
REQ-035 SHALL check nominal flow: key_valid = 1, in_valid pulse -> dp_load and key_start for 1 cycle, round steps 0..10, stage trace ARK,(SB,SR,MC,ARK)x9,SB,SR,ARK, out_valid at edge 52.
REQ-036 SHALL check key stall: key_valid = 0 for 3 cycles in the round-5 KWAIT -> out_valid at edge 55, round held at 5.
REQ-037 SHALL check backpressure: out_ready = 0 for 4 cycles in DONE -> out_valid held, round = 10; out_ready = 1 -> IDLE, and back-to-back in_valid is accepted the next cycle.
REQ-038 SHALL check abort: abort in SB of round 3 -> IDLE next edge, round = 0, no out_valid; abort in DONE -> ignored.
REQ-039 SHALL check reset: rst_n low in MC of round 7 -> immediate IDLE, outputs at reset values, no out_valid after release.
